// File: rtl/uart_tx.sv
// 8N1 UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, CLKS_PER_BIT cycles each.
// All outputs are registered; en low freezes an in-flight frame. The DONE state clears done and returns to IDLE even when en is low.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE behaves like IDLE for one cycle, so a back-to-back start is taken here
          done  <= 1'b0;
          state <= IDLE;
          if (start && en) begin
            shreg <= in;
            out   <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= START;
          end
        end

        START: begin
          if (en) begin
            if (cnt == LAST_CNT) begin
              cnt     <= '0;
              out     <= shreg[0];
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end

        DATA: begin
          if (en) begin
            if (cnt == LAST_CNT) begin
              cnt <= '0;
              if (bit_idx == 3'd7) begin
                out   <= 1'b1;
                state <= STOP;
              end else begin
                // shreg[0] always holds the bit currently on the line
                shreg   <= {1'b0, shreg[7:1]};
                out     <= shreg[1];
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end

        STOP: begin
          if (en) begin
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              out   <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          out   <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks the line, busy and done on every cycle of each frame.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic [7:0] in;
  logic       out;
  logic       done;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx #(.CLKS_PER_BIT(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .in    (in),
    .out   (out),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Accepts a frame, then walks it to DONE. hold_at/hold_len drop en for hold_len
  // cycles once hold_at enabled cycles have elapsed; poke_at re-pulses start with in=0.
  task automatic run_frame(input logic [7:0] b, input int hold_at, input int hold_len,
                           input int poke_at, input int exp_len, input string tag);
    int e;
    int ticks;
    int hold_left;
    in = b; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_accept_out"}, out, 1'b0);
    chk({tag, "_accept_busy"}, busy, 1'b1);
    chk({tag, "_accept_done"}, done, 1'b0);
    e = 0; ticks = 0; hold_left = hold_len;
    while (e < 160 && ticks < 400) begin
      en    = (e == hold_at && hold_left > 0) ? 1'b0 : 1'b1;
      start = (e == poke_at) ? 1'b1 : 1'b0;
      in    = (e == poke_at) ? 8'h00 : b;
      tick();
      if (en) e++;
      else    hold_left--;
      ticks++;
      start = 1'b0;
      en    = 1'b1;
      if (e < 160) begin
        chk({tag, "_out"}, out, frame_bit(b, e / 16));
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_done_early"}, done, 1'b0);
      end
    end
    chk_int({tag, "_len"}, ticks, exp_len);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_out_at_done"}, out, 1'b1);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; en = 1'b1; start = 1'b1; in = 8'hAA;

    // Reset wins over a simultaneous start
    tick(); tick();
    chk("rst_out", out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    rst = 1'b0; start = 1'b1; en = 1'b0;
    tick();
    chk("en_low_start_busy", busy, 1'b0);
    chk("en_low_start_out", out, 1'b1);
    start = 1'b0; en = 1'b1;
    tick();

    run_frame(8'h55, -1, 0, -1, 160, "f55");
    // Back-to-back frame accepted in the DONE cycle
    run_frame(8'hA3, -1, 0, -1, 160, "fA3");
    tick();
    chk("fA3_done_clear", done, 1'b0);
    chk("fA3_idle_busy", busy, 1'b0);
    chk("fA3_idle_out", out, 1'b1);

    run_frame(8'hFF, -1, 0, -1, 160, "fFF");
    tick();
    chk("fFF_done_clear", done, 1'b0);

    run_frame(8'h55, -1, 0, 40, 160, "poke");
    seen_done = 0;
    repeat (30) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    chk_int("poke_no_second_frame", seen_done, 0);

    run_frame(8'h55, 70, 7, -1, 167, "hold");
    en = 1'b0;
    tick();
    chk("done_clear_en_low", done, 1'b0);
    chk("idle_busy_en_low", busy, 1'b0);
    en = 1'b1;
    tick();

    // Reset 50 cycles into a frame
    in = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_out", out, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    rst = 1'b0;
    seen_done = 0;
    repeat (200) begin
      tick();
      if (done === 1'b1 || busy === 1'b1 || out !== 1'b1) seen_done++;
    end
    chk_int("midrst_quiet", seen_done, 0);
    run_frame(8'h3C, -1, 0, -1, 160, "f3C");
    tick();
    chk("f3C_done_clear", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2 to 65535.
REQ-002 clk  input  1  system clock; all logic updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  enable; while low, the transmitter pauses.
REQ-005 start  input  1  request to transmit; single-cycle pulse or level.
REQ-006 in  input  8  byte to transmit.
REQ-007 out  output  1  serial line; idles high.
REQ-008 done  output  1  one-cycle pulse when a frame completes.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit CLKS_PER_BIT cycles long.
REQ-011 The design SHALL use five FSM states: IDLE, START, DATA, STOP, DONE.
REQ-012 In IDLE, a start request SHALL be accepted on a rising edge where start=1 and en=1.
  - The edge latches in into a shift register.
  - It drives out<=0, busy<=1, clears the bit-cycle counter, and enters START.
REQ-013 In IDLE, start=1 with en=0 SHALL be ignored.
REQ-014 In START, DATA or STOP, the bit-cycle counter SHALL increment on each enabled cycle.
  - When it reaches CLKS_PER_BIT-1, it SHALL wrap to 0 and the bit SHALL end.
REQ-015 At the end of START, out SHALL take data bit 0 and the FSM SHALL enter DATA with bit index 0.
REQ-016 At the end of each DATA bit, the bit index SHALL increment and out SHALL take the next bit.
  - After bit 7 ends, out<=1 and the FSM SHALL enter STOP.
REQ-017 At the end of STOP, the FSM SHALL enter DONE, drive busy<=0 and done<=1, and keep out=1.
REQ-018 DONE SHALL last exactly one cycle.
  - done<=0 on the next edge and the FSM returns to IDLE.
  - A start with en=1 sampled in DONE SHALL be accepted as in IDLE.
REQ-019 Timing: out SHALL fall on edge T (the accepting edge) and done SHALL be high during the cycle after edge T+10*CLKS_PER_BIT, when en stays high.
REQ-020 The start bit SHALL appear on out from edge T for CLKS_PER_BIT cycles; out SHALL be glitch-free (registered).
REQ-021 A start sampled while busy=1 SHALL be ignored.
  - A change on in while busy=1 SHALL NOT affect the frame in flight.
REQ-022 When en=0 during START, DATA or STOP, the counter, bit index, state and out SHALL hold.
  - The frame resumes when en returns high, extended by the number of en-low cycles.
REQ-023 When en=0 in DONE, done SHALL still deassert and the FSM SHALL still return to IDLE.
REQ-024 busy SHALL be high exactly from edge T to the edge that enters DONE; done and busy SHALL never be high together.

Reset
REQ-025 While rst=1 on a clock edge, the design SHALL go to state IDLE.
  - Outputs: out=1, busy=0, done=0.
  - Internal: counter=0, bit index=0, shift register=0.
REQ-026 rst SHALL take priority over all other inputs, including start.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; out SHALL return high on that edge.
REQ-028 After rst deasserts, the first possible accepting edge SHALL be the next edge.

Verification
REQ-029 CLKS_PER_BIT=16, en=1, in=0x55, start pulsed 1 cycle -> out bits 0,1,0,1,0,1,0,1,0,1, each 16 cycles; done high one cycle, 160 cycles after the accepting edge; busy high 160 cycles.
REQ-030 in=0xA3 issued the cycle after done -> out bits 0,1,1,0,0,0,1,0,1,1; single done pulse at +160 cycles.
REQ-031 in=0xFF -> out low for 16 cycles (start bit) then high for 144 cycles; done pulse at +160.
REQ-032 start re-pulsed and in changed to 0x00 at cycle +40 of a 0x55 frame -> frame unchanged; exactly one done; no second frame.
REQ-033 en held low for 7 cycles mid DATA bit 3 -> out, state and counter frozen; done arrives at +167 cycles.
REQ-034 rst pulsed at cycle +50 of a frame -> out=1, busy=0, done=0 on that edge; no done pulse follows; a new start after reset transmits normally.
